// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the
// multi-port integer register file.
package regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int AW_DEF   = $clog2(NREG_DEF);

  typedef logic [XLEN_DEF-1:0] xlen_t;
  typedef logic [AW_DEF-1:0]   reg_addr_t;

  // True when a is the hardwired zero register.
  function automatic logic is_zero_addr(
    input logic [AW_DEF-1:0] a,
    input int                zero_reg
  );
    return (zero_reg != 0) && (a == '0);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits, set at
// issue and cleared at writeback, plus rbusy lookup.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG     = NREG_DEF,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NWR-1:0]              wen,
  input  logic [NWR*$clog2(NREG)-1:0] waddr,
  input  logic                        iss_valid,
  input  logic [$clog2(NREG)-1:0]     iss_rd,
  input  logic [NRD*$clog2(NREG)-1:0] raddr,
  output logic [NRD-1:0]              rbusy
);

  localparam int AW = $clog2(NREG);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [AW-1:0]   wa [NWR];
  logic [AW-1:0]   ra [NRD];

  for (genvar k = 0; k < NWR; k++) begin : g_wa
    assign wa[k] = waddr[k*AW +: AW];
  end

  for (genvar j = 0; j < NRD; j++) begin : g_ra
    assign ra[j] = raddr[j*AW +: AW];
  end

  // Next busy vector: clears first, so a new issue wins.
  always_comb begin
    busy_d = busy_q;
    for (int k = 0; k < NWR; k++) begin
      if (wen[k]) busy_d[wa[k]] = 1'b0;
    end
    if (iss_valid) busy_d[iss_rd] = 1'b1;
    if (ZERO_REG != 0) busy_d[0] = 1'b0;
  end

  // Busy register with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  // Read-side lookup; a same-cycle writeback hides busy.
  always_comb begin
    rbusy = '0;
    for (int j = 0; j < NRD; j++) begin
      rbusy[j] = busy_q[ra[j]];
      if (BYPASS != 0) begin
        for (int k = 0; k < NWR; k++) begin
          if (wen[k] && (wa[k] == ra[j])) rbusy[j] = 1'b0;
        end
      end
      if ((ZERO_REG != 0) && (ra[j] == '0)) rbusy[j] = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: NRD async read / NWR sync write register
// file with optional write bypass and busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREG     = NREG_DEF,
  parameter int NRD      = 2,
  parameter int NWR      = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NWR-1:0]              wen,
  input  logic [NWR*$clog2(NREG)-1:0] waddr,
  input  logic [NWR*XLEN-1:0]         wdata,
  input  logic [NRD*$clog2(NREG)-1:0] raddr,
  output logic [NRD*XLEN-1:0]         rdata,
  output logic [NRD-1:0]              rbusy,
  input  logic                        iss_valid,
  input  logic [$clog2(NREG)-1:0]     iss_rd,
  input  logic [$clog2(NREG)-1:0]     dbg_addr,
  output logic [XLEN-1:0]             dbg_rdata
);

  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [AW-1:0]   wa     [NWR];
  logic [XLEN-1:0] wd     [NWR];
  logic [NWR-1:0]  wv;
  logic [AW-1:0]   ra     [NRD];
  logic [XLEN-1:0] rd_val [NRD];

  for (genvar k = 0; k < NWR; k++) begin : g_wp
    assign wa[k] = waddr[k*AW +: AW];
    assign wd[k] = wdata[k*XLEN +: XLEN];
    assign wv[k] = wen[k] &&
                   !((ZERO_REG != 0) && (wa[k] == '0));
  end

  for (genvar j = 0; j < NRD; j++) begin : g_rp
    assign ra[j] = raddr[j*AW +: AW];
    assign rdata[j*XLEN +: XLEN] = rd_val[j];
  end

  // Next array state; ascending scan lets the top port win.
  always_comb begin
    regs_d = regs_q;
    for (int k = 0; k < NWR; k++) begin
      if (wv[k]) regs_d[wa[k]] = wd[k];
    end
  end

  // Register array with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) regs_q <= '{default: '0};
    else       regs_q <= regs_d;
  end

  // Read muxes with optional same-cycle forwarding.
  always_comb begin
    for (int j = 0; j < NRD; j++) begin
      rd_val[j] = regs_q[ra[j]];
      if (BYPASS != 0) begin
        for (int k = 0; k < NWR; k++) begin
          if (wv[k] && (wa[k] == ra[j])) rd_val[j] = wd[k];
        end
      end
      if ((ZERO_REG != 0) && (ra[j] == '0)) rd_val[j] = '0;
    end
  end

  assign dbg_rdata = regs_q[dbg_addr];

  regfile_scoreboard #(
    .NREG     (NREG),
    .NRD      (NRD),
    .NWR      (NWR),
    .BYPASS   (BYPASS),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk       (clk),
    .reset     (reset),
    .wen       (wen),
    .waddr     (waddr),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .raddr     (raddr),
    .rbusy     (rbusy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed plus random checks of two
// regfile_mp instances (bypass on / off) against a model.
module tb_regfile_mp;

  logic        clk;
  logic        reset;
  logic [1:0]  wen;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic [9:0]  raddr;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  dbg_addr;
  logic [63:0] rdata1, rdata0;
  logic [1:0]  rbusy1, rbusy0;
  logic [31:0] dbg1, dbg0;

  int checks = 0;
  int failures = 0;

  logic [31:0] mreg  [32];
  bit          mbusy [32];

  regfile_mp #(
    .XLEN(32), .NREG(32), .NRD(2), .NWR(2),
    .BYPASS(1), .ZERO_REG(1)
  ) dut_b1 (
    .clk(clk), .reset(reset), .wen(wen), .waddr(waddr),
    .wdata(wdata), .raddr(raddr), .rdata(rdata1),
    .rbusy(rbusy1), .iss_valid(iss_valid), .iss_rd(iss_rd),
    .dbg_addr(dbg_addr), .dbg_rdata(dbg1)
  );

  regfile_mp #(
    .XLEN(32), .NREG(32), .NRD(2), .NWR(2),
    .BYPASS(0), .ZERO_REG(1)
  ) dut_b0 (
    .clk(clk), .reset(reset), .wen(wen), .waddr(waddr),
    .wdata(wdata), .raddr(raddr), .rdata(rdata0),
    .rbusy(rbusy0), .iss_valid(iss_valid), .iss_rd(iss_rd),
    .dbg_addr(dbg_addr), .dbg_rdata(dbg0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] wa(input int k);
    return waddr[k*5 +: 5];
  endfunction

  function automatic logic [31:0] wd(input int k);
    return wdata[k*32 +: 32];
  endfunction

  // Value a read of a should return this cycle.
  function automatic logic [31:0] exp_rd(input logic [4:0] a,
                                         input bit byp);
    if (a == 0) return 32'h0;
    if (byp) begin
      for (int k = 1; k >= 0; k--)
        if (wen[k] && wa(k) == a) return wd(k);
    end
    return mreg[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a,
                                    input bit byp);
    if (a == 0) return 1'b0;
    if (byp && ((wen[0] && wa(0) == a) ||
                (wen[1] && wa(1) == a))) return 1'b0;
    return mbusy[a];
  endfunction

  task automatic check_all();
    logic [4:0] a;
    for (int j = 0; j < 2; j++) begin
      a = raddr[j*5 +: 5];
      chk($sformatf("rd_b1[%0d]", j), rdata1[j*32 +: 32],
          exp_rd(a, 1'b1));
      chk($sformatf("rd_b0[%0d]", j), rdata0[j*32 +: 32],
          exp_rd(a, 1'b0));
      chk($sformatf("busy_b1[%0d]", j), {31'b0, rbusy1[j]},
          {31'b0, exp_busy(a, 1'b1)});
      chk($sformatf("busy_b0[%0d]", j), {31'b0, rbusy0[j]},
          {31'b0, exp_busy(a, 1'b0)});
    end
    chk("dbg_b1", dbg1, mreg[dbg_addr]);
    chk("dbg_b0", dbg0, mreg[dbg_addr]);
  endtask

  // Advance one clock and update the model.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        mreg[i] = '0;
        mbusy[i] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++)
        if (wen[k] && wa(k) != 0) mreg[wa(k)] = wd(k);
      for (int k = 0; k < 2; k++)
        if (wen[k]) mbusy[wa(k)] = 1'b0;
      if (iss_valid && iss_rd != 0) mbusy[iss_rd] = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    reset = 1'b0;
    wen = '0;
    waddr = '0;
    wdata = '0;
    iss_valid = 1'b0;
    iss_rd = '0;
  endtask

  task automatic step();
    #1;
    check_all();
    tick();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mreg[i] = '0;
      mbusy[i] = 1'b0;
    end
    idle();
    raddr = '0;
    dbg_addr = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Reset state across all addresses.
    for (int a = 0; a < 32; a++) begin
      raddr = {a[4:0], a[4:0]};
      dbg_addr = a[4:0];
      #1;
      chk("rst_rd_b1", rdata1[31:0], 32'h0);
      chk("rst_rd_b0", rdata0[63:32], 32'h0);
      chk("rst_busy", {30'b0, rbusy1 | rbusy0}, 32'h0);
      chk("rst_dbg", dbg1, 32'h0);
    end

    // Bypass vs registered read of a fresh write.
    idle();
    wen = 2'b01; waddr = {5'd0, 5'd5};
    wdata = {32'h0, 32'hDEADBEEF};
    raddr = {5'd0, 5'd5};
    #1;
    chk("byp_same", rdata1[31:0], 32'hDEADBEEF);
    chk("nobyp_same", rdata0[31:0], 32'h0);
    check_all();
    tick();
    idle();
    #1;
    chk("nobyp_next", rdata0[31:0], 32'hDEADBEEF);
    chk("byp_next", rdata1[31:0], 32'hDEADBEEF);

    // Two ports hit the same address; port 1 wins.
    wen = 2'b11; waddr = {5'd7, 5'd7};
    wdata = {32'h22, 32'h11};
    raddr = {5'd7, 5'd7};
    #1;
    chk("conf_byp", rdata1[63:32], 32'h22);
    tick();
    idle();
    #1;
    chk("conf_next_b1", rdata1[31:0], 32'h22);
    chk("conf_next_b0", rdata0[31:0], 32'h22);

    // Zero register ignores writes and issue.
    wen = 2'b01; waddr = {5'd0, 5'd0};
    wdata = {32'h0, 32'h1234};
    iss_valid = 1'b1; iss_rd = 5'd0;
    raddr = {5'd0, 5'd0};
    dbg_addr = 5'd0;
    #1;
    chk("zero_byp", rdata1[31:0], 32'h0);
    tick();
    idle();
    #1;
    chk("zero_rd", rdata1[31:0], 32'h0);
    chk("zero_busy", {30'b0, rbusy1 | rbusy0}, 32'h0);
    chk("zero_dbg", dbg1, 32'h0);

    // Scoreboard set / simultaneous set+clear / clear.
    raddr = {5'd9, 5'd9};
    iss_valid = 1'b1; iss_rd = 5'd9;
    #1;
    chk("sb_iss_same", {31'b0, rbusy1[0]}, 32'h0);
    tick();
    idle();
    #1;
    chk("sb_set", {31'b0, rbusy1[0]}, 32'h1);
    tick();
    wen = 2'b01; waddr = {5'd0, 5'd9};
    wdata = {32'h0, 32'h99};
    iss_valid = 1'b1; iss_rd = 5'd9;
    #1;
    chk("sb_wb_mask_b1", {31'b0, rbusy1[0]}, 32'h0);
    chk("sb_wb_nomask_b0", {31'b0, rbusy0[0]}, 32'h1);
    tick();
    idle();
    #1;
    chk("sb_set_wins", {31'b0, rbusy0[0]}, 32'h1);
    wen = 2'b10; waddr = {5'd9, 5'd0};
    wdata = {32'h9a, 32'h0};
    tick();
    idle();
    #1;
    chk("sb_clear", {31'b0, rbusy0[0]}, 32'h0);
    chk("sb_clear_data", rdata0[31:0], 32'h9a);

    // Fill 1..31, mark some busy, then reset with traffic.
    for (int a = 1; a < 32; a += 2) begin
      wen = (a < 31) ? 2'b11 : 2'b01;
      waddr = {5'(a + 1), 5'(a)};
      wdata = {32'h1000 + 32'(a + 1), 32'h1000 + 32'(a)};
      iss_valid = 1'b1; iss_rd = 5'(a + 3);
      raddr = {5'(a - 1), 5'(a)};
      dbg_addr = 5'(a - 1);
      step();
    end
    idle();
    reset = 1'b1;
    wen = 2'b11; waddr = {5'd4, 5'd3};
    wdata = {32'hAAAA, 32'hBBBB};
    iss_valid = 1'b1; iss_rd = 5'd6;
    tick();
    idle();
    for (int a = 0; a < 32; a++) begin
      raddr = {a[4:0], a[4:0]};
      dbg_addr = a[4:0];
      #1;
      chk("rst2_rd", rdata0[31:0] | rdata1[63:32], 32'h0);
      chk("rst2_busy", {30'b0, rbusy1 | rbusy0}, 32'h0);
      chk("rst2_dbg", dbg0, 32'h0);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 39) == 0);
      wen = 2'($urandom);
      for (int k = 0; k < 2; k++) begin
        waddr[k*5 +: 5] = $urandom_range(0, 1) != 0 ?
                          5'($urandom_range(0, 7)) : 5'($urandom);
        raddr[k*5 +: 5] = $urandom_range(0, 1) != 0 ?
                          5'($urandom_range(0, 7)) : 5'($urandom);
      end
      wdata = {$urandom, $urandom};
      iss_valid = 1'($urandom);
      iss_rd = $urandom_range(0, 1) != 0 ?
               5'($urandom_range(0, 7)) : 5'($urandom);
      dbg_addr = 5'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the superscalar/OoO-lite core.
- Provides:
  - NRD asynchronous read ports and NWR synchronous write ports.
  - Optional same-cycle write-to-read bypass.
  - A per-register busy scoreboard (set at issue, cleared at writeback) that decode uses for RAW stall decisions.
- Sits between decode/issue (read and issue ports) and the writeback stage (write ports).

Parameters:
- XLEN, 32, data width in bits.
- NREG, 32, number of architectural registers; must be a power of 2 and ≥ 2.
- NRD, 2, number of read ports.
- NWR, 1, number of write ports (1..4).
- BYPASS, 1, 1 = reads see same-cycle writes; 0 = reads see registered state only.
- ZERO_REG, 1, 1 = register 0 is hardwired to zero and is never busy.
- AW, $clog2(NREG), derived register-address width; not overridable.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high; clears all registers and all busy bits.
- wen  in  NWR  per-port write enable.
- waddr  in  NWR*AW  per-port write address; port k occupies bits [k*AW +: AW].
- wdata  in  NWR*XLEN  per-port write data.
- raddr  in  NRD*AW  per-port read address.
- rdata  out  NRD*XLEN  per-port read data, combinational.
- rbusy  out  NRD  busy flag of each read address, combinational.
- iss_valid  in  1  an instruction with a destination register issues this cycle.
- iss_rd  in  AW  destination register of the issuing instruction.
- dbg_addr  in  AW  debug/testbench read address.
- dbg_rdata  out  XLEN  debug read data; raw array value, no bypass.

Behaviour:
- Reset:
  - On a clk edge with reset=1, all NREG registers become 0 and all busy bits become 0.
  - Writes and issue in that cycle are ignored.
  - Reset may be asserted mid-operation; the state is fully clear on the next cycle.
- Write:
  - For each port k with wen[k]=1, reg[waddr[k]] <= wdata[k] at the clk edge.
  - Write latency is 1 cycle.
- Write conflict:
  - When several ports write the same address in one cycle, the highest-index port wins.
  - The losing data is discarded silently.
- Zero register: when ZERO_REG=1,
  - writes to address 0 are dropped;
  - reads of address 0 return 0 regardless of bypass;
  - issue to address 0 does not set busy.
- Read:
  - rdata[j] is combinational from raddr[j].
  - BYPASS=1: if any wen[k] with waddr[k]==raddr[j] (and not the dropped zero case), return wdata of the highest-index matching k; otherwise return the array value.
  - BYPASS=0: always return the array value; the new value is visible the cycle after the write.
- Scoreboard:
  - busy[NREG] is registered state.
  - Set: iss_valid=1 sets busy[iss_rd] at the clk edge.
  - Clear: each wen[k] clears busy[waddr[k]] at the clk edge.
  - Same register set and cleared in one cycle: set wins, because a new producer supersedes the old one.
  - Issuing to an already-busy register keeps it busy. There is no counting; WAW ordering is the issue logic's responsibility.
- rbusy:
  - rbusy[j] = busy[raddr[j]].
  - When BYPASS=1, rbusy[j] is masked to 0 if a same-cycle write targets raddr[j].
  - A same-cycle issue does not affect rbusy until the next cycle.
  - rbusy is always 0 for address 0 when ZERO_REG=1.
- Reset values of outputs:
  - After reset, rdata = 0 for every address and rbusy = 0.
  - dbg_rdata = 0.
- No X propagation: uninitialised state is impossible after the first reset. Before the first reset, outputs are unspecified.

Decomposition:
- Package regfile_pkg holds:
  - the default XLEN/NREG constants;
  - the typedef xlen_t (logic [XLEN-1:0]);
  - the typedef reg_addr_t (logic [AW-1:0]).
- One natural sub-module, regfile_scoreboard: the busy vector with its set/clear priority, plus the NRD-wide rbusy lookup.
- Write-port priority and the bypass muxes stay in regfile_mp.

Test Plan:
1. Reset, then read all addresses -> rdata=0 and rbusy=0 everywhere; dbg_rdata=0.
2. wen[0]=1, waddr=5, wdata=0xDEADBEEF, raddr[0]=5 in the same cycle:
   - BYPASS=1 -> rdata[0]=0xDEADBEEF in that cycle.
   - BYPASS=0 -> the old value in that cycle, 0xDEADBEEF the next cycle.
3. NWR=2, both ports write address 7 (port0 0x11, port1 0x22) -> next cycle reg7=0x22; the same-cycle bypass read also returns 0x22.
4. Write 0x1234 to address 0 with ZERO_REG=1, and issue iss_rd=0 -> rdata for address 0 stays 0 and rbusy stays 0.
5. Scoreboard sequence, check each step:
   - Issue rd=9 -> rbusy(9)=1 on the next cycle.
   - In a later cycle, writeback to 9 together with a new issue to 9 -> busy(9) stays 1.
   - A further writeback to 9 -> busy(9)=0.
6. Fill regs 1..31 with distinct values and set several busy bits, then assert reset for 1 cycle together with wen=1 and iss_valid=1 -> everything 0 on the next cycle; the simultaneous write and issue are ignored.
